// File: rtl/lc3_decode.sv
// LC-3 decode stage: captures IR/NPC on enable_decode and decodes the execute/writeback/memory control words.
// Latency: 1 cycle from enable_decode to registered outputs; decode_valid pulses in that same cycle.
// Backpressure: none; each enable_decode is a capture, and all outputs hold while it is low.
module lc3_decode #(
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_decode,
  input  logic [DW-1:0]    instr_dout,
  input  logic [DW-1:0]    npc_in,
  output logic [DW-1:0]    IR,
  output logic [DW-1:0]    npc_out,
  output logic [5:0]       E_Control,
  output logic [1:0]       W_Control,
  output logic             Mem_Control,
  output logic             decode_valid,
  output logic             illegal_op,
  output logic [CNT_W-1:0] decode_count,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [3:0]       w_opcode;
  logic [1:0]       w_alu;
  logic [1:0]       w_pcs1;
  logic             w_pcs2;
  logic             w_op2;
  logic [1:0]       w_wsel;
  logic             w_mem;
  logic             w_illegal;

  logic [DW-1:0]    r_ir;
  logic [DW-1:0]    r_npc;
  logic [5:0]       r_e_ctrl;
  logic [1:0]       r_w_ctrl;
  logic             r_mem_ctrl;
  logic             r_valid;
  logic             r_illegal;
  logic [CNT_W-1:0] r_decode_count;
  logic [CNT_W-1:0] r_illegal_count;

  assign w_opcode = instr_dout[15:12];

  // Decode the incoming instruction word; unsupported opcodes leave every control field at 0.
  always_comb begin
    w_alu     = 2'b00;
    w_pcs1    = 2'b00;
    w_pcs2    = 1'b0;
    w_op2     = 1'b0;
    w_wsel    = 2'b00;
    w_mem     = 1'b0;
    w_illegal = 1'b0;
    case (w_opcode)
      OP_ADD: w_op2 = ~instr_dout[5];
      OP_AND: begin
        w_alu = 2'b01;
        w_op2 = ~instr_dout[5];
      end
      OP_NOT: w_alu = 2'b10;
      OP_BR: begin
        w_pcs1 = 2'b01;
        w_pcs2 = 1'b1;
      end
      OP_JMP: w_pcs1 = 2'b11;
      OP_LD, OP_LDI: begin
        w_pcs1 = 2'b01;
        w_pcs2 = 1'b1;
        w_wsel = 2'b01;
        w_mem  = (w_opcode == OP_LDI);
      end
      OP_LDR: begin
        w_pcs1 = 2'b10;
        w_wsel = 2'b01;
      end
      OP_ST, OP_STI: begin
        w_pcs1 = 2'b01;
        w_pcs2 = 1'b1;
        w_mem  = (w_opcode == OP_STI);
      end
      OP_STR: w_pcs1 = 2'b10;
      OP_LEA: begin
        w_pcs1 = 2'b01;
        w_pcs2 = 1'b1;
        w_wsel = 2'b10;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Capture instruction, NPC and decoded controls; reset overrides a simultaneous enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir       <= '0;
      r_npc      <= '0;
      r_e_ctrl   <= '0;
      r_w_ctrl   <= '0;
      r_mem_ctrl <= 1'b0;
      r_illegal  <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= enable_decode;
      if (enable_decode) begin
        r_ir       <= instr_dout;
        r_npc      <= npc_in;
        r_e_ctrl   <= {w_alu, w_pcs1, w_pcs2, w_op2};
        r_w_ctrl   <= w_wsel;
        r_mem_ctrl <= w_mem;
        r_illegal  <= w_illegal;
      end
    end
  end

  // Saturating statistics: every capture, and every capture of an unsupported opcode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_decode_count  <= '0;
      r_illegal_count <= '0;
    end else if (enable_decode) begin
      if (r_decode_count != CNT_MAX)
        r_decode_count <= r_decode_count + CNT_W'(1);
      if (w_illegal && (r_illegal_count != CNT_MAX))
        r_illegal_count <= r_illegal_count + CNT_W'(1);
    end
  end

  assign IR            = r_ir;
  assign npc_out       = r_npc;
  assign E_Control     = r_e_ctrl;
  assign W_Control     = r_w_ctrl;
  assign Mem_Control   = r_mem_ctrl;
  assign decode_valid  = r_valid;
  assign illegal_op    = r_illegal;
  assign decode_count  = r_decode_count;
  assign illegal_count = r_illegal_count;

endmodule

// File: tb/tb_lc3_decode.sv
// Bench for lc3_decode: directed steps followed by random traffic against a table-driven model.
// Inputs change on the falling edge; outputs are compared 1 time unit after the rising edge.
// Counters are built 4 bits wide so saturation is reachable quickly.
module tb_lc3_decode;

  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic          enable_decode;
  logic [15:0]   instr_dout;
  logic [15:0]   npc_in;
  logic [15:0]   IR;
  logic [15:0]   npc_out;
  logic [5:0]    E_Control;
  logic [1:0]    W_Control;
  logic          Mem_Control;
  logic          decode_valid;
  logic          illegal_op;
  logic [CW-1:0] decode_count;
  logic [CW-1:0] illegal_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected state, written in instruction-level terms.
  logic [15:0] m_ir, m_npc;
  logic [5:0]  m_e;
  logic [1:0]  m_w;
  logic        m_mem, m_ill, m_dv;
  int          m_dc, m_ic;

  // Per-opcode mnemonic table: E_Control base, writeback source, indirect flag, illegal flag.
  logic [5:0] e_tab   [16];
  logic [1:0] w_tab   [16];
  logic       mem_tab [16];
  logic       ill_tab [16];

  lc3_decode #(.DW(16), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable_decode (enable_decode),
    .instr_dout    (instr_dout),
    .npc_in        (npc_in),
    .IR            (IR),
    .npc_out       (npc_out),
    .E_Control     (E_Control),
    .W_Control     (W_Control),
    .Mem_Control   (Mem_Control),
    .decode_valid  (decode_valid),
    .illegal_op    (illegal_op),
    .decode_count  (decode_count),
    .illegal_count (illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill_tables();
    for (int i = 0; i < 16; i++) begin
      e_tab[i] = 6'b000000; w_tab[i] = 2'b00; mem_tab[i] = 1'b0; ill_tab[i] = 1'b0;
    end
    e_tab[4'h0] = 6'b000110;                          // BR   : offset9 + NPC
    e_tab[4'h1] = 6'b000000;                          // ADD  : op2 from imm bit
    e_tab[4'h2] = 6'b000110; w_tab[4'h2] = 2'b01;     // LD
    e_tab[4'h3] = 6'b000110;                          // ST
    e_tab[4'h5] = 6'b010000;                          // AND
    e_tab[4'h6] = 6'b001000; w_tab[4'h6] = 2'b01;     // LDR
    e_tab[4'h7] = 6'b001000;                          // STR
    e_tab[4'h9] = 6'b100000;                          // NOT
    e_tab[4'hA] = 6'b000110; w_tab[4'hA] = 2'b01; mem_tab[4'hA] = 1'b1; // LDI
    e_tab[4'hB] = 6'b000110; mem_tab[4'hB] = 1'b1;    // STI
    e_tab[4'hC] = 6'b001100;                          // JMP
    e_tab[4'hE] = 6'b000110; w_tab[4'hE] = 2'b10;     // LEA
    ill_tab[4'h4] = 1'b1; ill_tab[4'h8] = 1'b1; ill_tab[4'hD] = 1'b1; ill_tab[4'hF] = 1'b1;
  endtask

  task automatic model_edge(input logic rst, input logic en, input logic [15:0] ins, input logic [15:0] npc);
    int op;
    op = int'(ins[15:12]);
    if (rst) begin
      m_ir = '0; m_npc = '0; m_e = '0; m_w = '0; m_mem = 0; m_ill = 0; m_dv = 0;
      m_dc = 0; m_ic = 0;
    end else begin
      m_dv = en;
      if (en) begin
        m_ir  = ins;
        m_npc = npc;
        m_e   = e_tab[op];
        if ((op == 1 || op == 5) && !ins[5]) m_e[0] = 1'b1;
        m_w   = w_tab[op];
        m_mem = mem_tab[op];
        m_ill = ill_tab[op];
        if (m_dc < (1 << CW) - 1) m_dc++;
        if (ill_tab[op] && m_ic < (1 << CW) - 1) m_ic++;
      end
    end
  endtask

  task automatic check_all(input string step);
    check({step, ".IR"},  32'(IR),            32'(m_ir));
    check({step, ".NPC"}, 32'(npc_out),       32'(m_npc));
    check({step, ".E"},   32'(E_Control),     32'(m_e));
    check({step, ".W"},   32'(W_Control),     32'(m_w));
    check({step, ".MEM"}, 32'(Mem_Control),   32'(m_mem));
    check({step, ".DV"},  32'(decode_valid),  32'(m_dv));
    check({step, ".ILL"}, 32'(illegal_op),    32'(m_ill));
    check({step, ".DC"},  32'(decode_count),  32'(m_dc));
    check({step, ".IC"},  32'(illegal_count), 32'(m_ic));
  endtask

  // One clock: drive on the falling edge, advance the model at the rising edge, compare just after.
  task automatic cycle(input logic rst, input logic en, input logic [15:0] ins, input logic [15:0] npc,
                       input string step);
    @(negedge clk);
    reset = rst; enable_decode = en; instr_dout = ins; npc_in = npc;
    @(posedge clk);
    model_edge(rst, en, ins, npc);
    #1;
    check_all(step);
  endtask

  initial begin
    logic [15:0] ins;
    fill_tables();
    reset = 1'b1; enable_decode = 1'b0; instr_dout = '0; npc_in = '0;

    // Reset wins over a simultaneous enable.
    cycle(1, 1, 16'h1042, 16'h3001, "rst_pri");
    check("rst_pri.dc_const", 32'(decode_count), 32'd0);
    check("rst_pri.ir_const", 32'(IR), 32'd0);

    // ADD register mode, then immediate mode.
    cycle(0, 1, 16'h1042, 16'h3001, "add_reg");
    check("add_reg.ir_const",  32'(IR), 32'h1042);
    check("add_reg.npc_const", 32'(npc_out), 32'h3001);
    check("add_reg.e_const",   32'(E_Control), 32'b000001);
    check("add_reg.dv_const",  32'(decode_valid), 32'd1);
    cycle(0, 0, 16'h1042, 16'h3001, "add_gap");
    check("add_gap.dv_const",  32'(decode_valid), 32'd0);
    cycle(0, 1, 16'h1065, 16'h3002, "add_imm");
    check("add_imm.e_const",   32'(E_Control), 32'b000000);

    // LDI.
    cycle(0, 1, 16'hA202, 16'h3003, "ldi");
    check("ldi.e_const",   32'(E_Control), 32'b000110);
    check("ldi.w_const",   32'(W_Control), 32'b01);
    check("ldi.mem_const", 32'(Mem_Control), 32'd1);

    // LEA then hold for three cycles with a JMP on the bus, then capture the JMP.
    cycle(0, 1, 16'hE1FF, 16'h3004, "lea");
    check("lea.e_const", 32'(E_Control), 32'b000110);
    check("lea.w_const", 32'(W_Control), 32'b10);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 16'hC1C0, 16'h7777, "hold");
      check("hold.ir_const", 32'(IR), 32'hE1FF);
      check("hold.e_const",  32'(E_Control), 32'b000110);
    end
    cycle(0, 1, 16'hC1C0, 16'h3005, "jmp");
    check("jmp.e_const", 32'(E_Control), 32'b001100);
    check("jmp.w_const", 32'(W_Control), 32'b00);

    // Illegal opcode after a fresh reset, then a legal AND clears the flag.
    cycle(1, 0, 16'h0000, 16'h0000, "rst2");
    cycle(0, 1, 16'hD000, 16'h4000, "illegal");
    check("illegal.ill_const", 32'(illegal_op), 32'd1);
    check("illegal.e_const",   32'(E_Control), 32'd0);
    check("illegal.ir_const",  32'(IR), 32'hD000);
    check("illegal.ic_const",  32'(illegal_count), 32'd1);
    cycle(0, 1, 16'h5042, 16'h4001, "and");
    check("and.ill_const", 32'(illegal_op), 32'd0);
    check("and.e_const",   32'(E_Control), 32'b010001);

    // Saturation: 20 back-to-back captures from reset.
    cycle(1, 0, 16'h0000, 16'h0000, "rst3");
    for (int i = 0; i < 20; i++) begin
      ins = 16'($urandom);
      cycle(0, 1, ins, 16'($urandom), "sat");
    end
    check("sat.dc_const", 32'(decode_count), 32'hF);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 70),
            16'($urandom), 16'($urandom), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_decode.md
Name: lc3_decode

Overview:
- LC-3 decode stage, directly downstream of the fetch stage.
- Captures the instruction word returned by instruction memory together with the fetch stage's NPC when the controller asserts enable_decode (controller state CNTRL_DECODE).
- Produces registered IR, NPC and the execute/writeback/memory control words consumed by the execute and writeback stages.
- Keeps saturating statistics counters for decoded and illegal instructions.

Parameters:
- DW, 16, instruction and PC width.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable_decode  input  1  capture strobe from the controller.
- instr_dout  input  DW  instruction word from instruction memory.
- npc_in  input  DW  PC+1 from the fetch stage.
- IR  output  DW  registered instruction.
- npc_out  output  DW  registered NPC.
- E_Control  output  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- W_Control  output  2  writeback source: 00 ALU, 01 memory, 10 PC-relative address.
- Mem_Control  output  1  1 = indirect access (LDI/STI).
- decode_valid  output  1  one-cycle pulse: outputs updated this cycle.
- illegal_op  output  1  registered: captured opcode unsupported.
- decode_count  output  CNT_W  accepted instructions, saturating.
- illegal_count  output  CNT_W  illegal instructions, saturating.

Behaviour:
- Reset (synchronous, highest priority, overrides enable_decode): every output goes to 0 on the next edge.
- Capture: on a rising edge with reset=0 and enable_decode=1:
  - IR <= instr_dout; npc_out <= npc_in.
  - Control outputs are decoded from instr_dout, not from the old IR.
  - Latency is 1 cycle.
- Hold: with enable_decode=0, IR, npc_out, E_Control, W_Control, Mem_Control and illegal_op hold their values regardless of input changes.
- decode_valid <= enable_decode & ~reset every cycle. Back-to-back enables give back-to-back pulses and back-to-back captures.
- Decode table, keyed on opcode = instr_dout[15:12]:
  - ADD 0001: alu 00; pcs1 00; pcs2 0; op2select = ~instr_dout[5]; W 00; Mem 0.
  - AND 0101: alu 01; otherwise as ADD.
  - NOT 1001: alu 10; op2select 0; W 00.
  - BR 0000: alu 00; pcs1 01 (offset9); pcs2 1 (NPC); op2 0; W 00.
  - JMP 1100: pcs1 11 (zero); pcs2 0 (base register); W 00.
  - LD 0010 / LDI 1010: pcs1 01; pcs2 1; W 01. Mem = 1 for LDI only.
  - LDR 0110: pcs1 10 (offset6); pcs2 0; W 01; Mem 0.
  - ST 0011 / STI 1011: pcs1 01; pcs2 1; W 00. Mem = 1 for STI only.
  - STR 0111: pcs1 10; pcs2 0; W 00.
  - LEA 1110: pcs1 01; pcs2 1; W 10.
  - Fields not listed above are 0.
- Illegal opcodes (0100, 1000, 1101, 1111):
  - IR and npc_out are still captured.
  - E_Control, W_Control and Mem_Control are forced to 0; illegal_op = 1.
  - illegal_op clears on the next legal capture.
- Counters:
  - decode_count increments on every capture.
  - illegal_count increments on every illegal capture.
  - Both saturate at all-ones; no wrap.
- Reset asserted in the same cycle as enable_decode: reset wins; the instruction is not counted.
- No combinational path from inputs to outputs.

Test Plan:
- Reset priority: reset=1, enable_decode=1, instr_dout=16'h1042 -> next edge all outputs 0, decode_count=0.
- ADD register and immediate modes:
  - instr_dout=16'h1042, npc_in=16'h3001, enable 1 cycle -> IR=16'h1042, npc_out=16'h3001, E_Control=6'b000001, W=00, Mem=0, decode_valid pulses 1 cycle.
  - Then 16'h1065 -> E_Control=6'b000000.
- LDI: instr_dout=16'hA202 -> E_Control=6'b000110, W_Control=01, Mem_Control=1, illegal_op=0.
- Hold: capture 16'hE1FF (expect E_Control=6'b000110, W=10), then enable_decode=0 for 3 cycles while instr_dout=16'hC1C0 -> all outputs unchanged, decode_valid=0. Then enable -> E_Control=6'b001100, W=00.
- Illegal opcode: instr_dout=16'hD000 -> illegal_op=1, E/W/Mem=0, IR=16'hD000, illegal_count=1. Next legal capture of 16'h5042 -> illegal_op=0, E_Control=6'b010001.
- Saturation (CNT_W=4): 20 consecutive captures -> decode_count stops at 4'hF.
